fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter PC_W, default 12, word-address width of the instruction memory port (byte PC is PC_W+2 bits).
REQ-002 Parameter DEPTH, default 4, prefetch buffer entries; power of two, DEPTH >= 2.
REQ-003 Parameter MAX_OUT, default 2, maximum outstanding memory requests; 1 <= MAX_OUT <= DEPTH.
REQ-004 Parameter RESET_PC, default 32'h0, byte PC after reset; word-aligned.
REQ-005 One clock, clk; reset is synchronous and active-high, port named reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 imem_req_valid  out  1  request pending.
REQ-009 imem_req_ready  in  1  memory accepts request this cycle.
REQ-010 imem_req_addr  out  PC_W  word address (byte PC [PC_W+1:2]).
REQ-011 imem_rsp_valid  in  1  in-order response strobe, no backpressure.
REQ-012 imem_rsp_data  in  32  instruction word.
REQ-013 redirect_valid  in  1  branch/jump/trap target this cycle.
REQ-014 redirect_pc  in  32  target byte address.
REQ-015 instr_valid  out  1  buffer head valid.
REQ-016 instr_ready  in  1  consumer takes head.
REQ-017 instr_data  out  32  head instruction.
REQ-018 instr_pc  out  32  head byte PC, zero-extended above PC_W+2 bits.
REQ-019 fetch_trap  out  1  misaligned redirect latched.
REQ-020 fill_count  out  $clog2(DEPTH)+1  buffered entries.

Function
REQ-021 FSM states SHALL be FETCH, FLUSH, TRAP.
REQ-022 Request handshake completes when imem_req_valid && imem_req_ready; fetch PC then advances by 4, wrapping modulo 2^(PC_W+2).
REQ-023 imem_req_valid SHALL be high only in FETCH when outstanding < MAX_OUT and fill_count + outstanding < DEPTH, guaranteeing every response a slot.
REQ-024 imem_req_addr SHALL be stable while imem_req_valid is high and not accepted.
REQ-025 Each non-discarded response SHALL be written to the buffer tail with its request PC (PC tag FIFO, depth MAX_OUT); it is visible on instr_* the next cycle (one-cycle latency).
REQ-026 Pop on instr_valid && instr_ready; simultaneous push and pop SHALL leave fill_count unchanged, including when full or empty.
REQ-027 Outstanding counter: +1 on request accept, -1 on response; both in one cycle leaves it unchanged.
REQ-028 Redirect SHALL take priority over all same-cycle events: buffer emptied, same-cycle pop and response ignored, same-cycle request counted as outstanding.
REQ-029 Aligned redirect (redirect_pc[1:0]==0): fetch PC <= redirect_pc; next state FLUSH if outstanding (after REQ-028) > 0, else FETCH.
REQ-030 FLUSH: no requests; responses discarded, decrementing outstanding; exit to FETCH the cycle outstanding reaches 0.
REQ-031 Misaligned redirect: buffer emptied, fetch_trap=1, state TRAP; in-flight responses still discarded; no requests issued.
REQ-032 TRAP exits only on an aligned redirect, per REQ-029; fetch_trap clears that cycle.
REQ-033 A redirect arriving in FLUSH SHALL update fetch PC and remain in FLUSH while outstanding > 0.
REQ-034 instr_valid SHALL be 0 in FLUSH and TRAP.

Reset
REQ-035 On reset: state FETCH, fetch PC RESET_PC, fill_count 0, outstanding 0, instr_valid 0, fetch_trap 0, imem_req_valid 0 during the reset cycle.
REQ-036 Reset mid-operation SHALL abandon in-flight requests; the memory is reset concurrently, so no responses follow.

Structure
REQ-037 FSM state encoding and instruction-width constants SHALL live in shared package rv32i_pkg.
REQ-038 The buffer SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; registered read, full/empty/count).
REQ-039 No combinational path from imem_rsp_* to instr_* or imem_req_*.

Verification
REQ-040 Reset, imem_req_ready=1, one-cycle response latency, instr_ready=1 -> instr_pc 0x0,0x4,0x8,... one per cycle after pipeline fill.
REQ-041 instr_ready=0 with DEPTH=4 -> fill_count stops at 4, imem_req_valid low, no outstanding overflow; ready=1 resumes in order.
REQ-042 Redirect to 0x100 with 2 outstanding -> FLUSH, two responses dropped, next instr_pc = 0x100.
REQ-043 Redirect to 0x102 -> fetch_trap=1, no requests; redirect to 0x200 -> trap clears, instr_pc 0x200.
REQ-044 PC_W=4, fetch from 0x3C -> next instr_pc 0x00 (wrap).
REQ-045 Redirect, response and pop in one cycle -> buffer empty, response ignored, fill_count 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: instruction width and fetch-queue FSM encoding.
package rv32i_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN    = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1,
        TRAP  = 2'd2
    } fq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head read (RAM-style array plus output register).
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign head_data = head_reg;

    always_comb begin
        do_pop      = pop && !empty;
        do_push     = push && (!full || do_pop);
        rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        count_next  = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_next = count_reg - (AW+1)'(1);
        end
        // The next head is the word being written when the queue would otherwise be empty.
        if (do_push && (rd_ptr_next == wr_ptr_reg)) begin
            head_next = push_data;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues in-order word fetches, buffers responses with their PCs,
// and handles redirects (flushing in-flight responses) and misaligned-target traps.
module fetch_queue
    import rv32i_pkg::*;
#(
    parameter int          PC_W     = 12,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [PC_W-1:0]          imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [INSTR_W-1:0]       imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr_data,
    output logic [XLEN-1:0]          instr_pc,
    output logic                     fetch_trap,
    output logic [$clog2(DEPTH):0]   fill_count
);

    localparam int OUT_W  = $clog2(MAX_OUT + 1);
    localparam int TAG_AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int BUF_W  = PC_W + INSTR_W;

    fq_state_e         state_reg;
    fq_state_e         state_next;
    logic [PC_W-1:0]   fetch_pc_reg;
    logic [PC_W-1:0]   fetch_pc_next;
    logic [OUT_W-1:0]  out_reg;
    logic [OUT_W-1:0]  out_next;
    logic [PC_W-1:0]   tag_mem [MAX_OUT];
    logic [TAG_AW-1:0] tag_wr_reg;
    logic [TAG_AW-1:0] tag_rd_reg;

    logic              req_fire;
    logic              redirect_aligned;
    logic              buf_push;
    logic              buf_pop;
    logic              buf_full;
    logic              buf_empty;
    logic [BUF_W-1:0]  buf_head;
    logic [PC_W-1:0]   head_pc;

    generate
        if (PC_W + 2 < XLEN) begin : g_pc_hi
            logic unused_redirect_hi;
            assign unused_redirect_hi = ^redirect_pc[XLEN-1:PC_W+2];
        end
    endgenerate

    // Request only when every in-flight response is guaranteed a buffer slot.
    assign imem_req_valid = !reset && (state_reg == FETCH) && !buf_full
                         && (int'(out_reg) < MAX_OUT)
                         && ((int'(fill_count) + int'(out_reg)) < DEPTH);
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign redirect_aligned = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign buf_push = imem_rsp_valid && (state_reg == FETCH) && !redirect_valid;
    assign buf_pop  = instr_valid && instr_ready && !redirect_valid;

    sync_fifo #(
        .WIDTH (BUF_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (buf_push),
        .push_data ({tag_mem[tag_rd_reg], imem_rsp_data}),
        .pop       (buf_pop),
        .head_data (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (fill_count)
    );

    assign head_pc     = buf_head[BUF_W-1:INSTR_W];
    assign instr_data  = buf_head[INSTR_W-1:0];
    assign instr_valid = (state_reg == FETCH) && !buf_empty;
    assign fetch_trap  = (state_reg == TRAP);

    always_comb begin
        instr_pc = '0;
        instr_pc[PC_W+1:2] = head_pc;
    end

    always_comb begin
        out_next = out_reg;
        if (req_fire && !imem_rsp_valid) begin
            out_next = out_reg + OUT_W'(1);
        end else if (imem_rsp_valid && !req_fire) begin
            out_next = out_reg - OUT_W'(1);
        end
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + PC_W'(1);
        end
        if (redirect_valid) begin
            if (redirect_aligned) begin
                fetch_pc_next = redirect_pc[PC_W+1:2];
                state_next    = (out_next != '0) ? FLUSH : FETCH;
            end else begin
                state_next = TRAP;
            end
        end else if (state_reg == FLUSH) begin
            if (out_next == '0) begin
                state_next = FETCH;
            end
        end
    end

    // Request PCs travel alongside the memory so each response can be tagged in order.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_reg] <= fetch_pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= FETCH;
            fetch_pc_reg <= RESET_PC[PC_W+1:2];
            out_reg      <= '0;
            tag_wr_reg   <= '0;
            tag_rd_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            out_reg      <= out_next;
            if (req_fire) begin
                tag_wr_reg <= (tag_wr_reg == TAG_AW'(MAX_OUT - 1)) ? '0 : tag_wr_reg + TAG_AW'(1);
            end
            if (imem_rsp_valid) begin
                tag_rd_reg <= (tag_rd_reg == TAG_AW'(MAX_OUT - 1)) ? '0 : tag_rd_reg + TAG_AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a default instance plus a PC_W=4 instance driven in lockstep.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;

    logic        imem_req_valid;
    logic [11:0] imem_req_addr;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        fetch_trap;
    logic [2:0]  fill_count;

    logic        s_imem_req_valid;
    logic [3:0]  s_imem_req_addr;
    logic        s_instr_valid;
    logic [31:0] s_instr_data;
    logic [31:0] s_instr_pc;
    logic        s_fetch_trap;
    logic [2:0]  s_fill_count;

    always #5 clk = ~clk;

    fetch_queue u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fetch_trap     (fetch_trap),
        .fill_count     (fill_count)
    );

    fetch_queue #(.PC_W(4)) u_dut_small (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (s_imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (s_imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (s_instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (s_instr_data),
        .instr_pc       (s_instr_pc),
        .fetch_trap     (s_fetch_trap),
        .fill_count     (s_fill_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;
    int          n_accepts = 0;
    int          cyc      = 0;
    int          lat      = 1;
    bit          hold     = 1'b0;
    logic [31:0] exp_pc   = 32'h0;
    logic [11:0] addr_q [$];
    int          due_q  [$];

    function automatic logic [31:0] data_of(input logic [11:0] a);
        return 32'hC0DE_0000 | {20'h0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: memory model delivers a due response, records an accepted request, then the edge.
    task automatic tick();
        if (reset) begin
            addr_q.delete();
            due_q.delete();
            imem_rsp_valid = 1'b0;
        end else if (!hold && due_q.size() > 0 && due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = data_of(addr_q[0]);
            void'(addr_q.pop_front());
            void'(due_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            addr_q.push_back(imem_req_addr);
            due_q.push_back(cyc + lat);
            n_accepts++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (instr_valid && instr_ready) begin
                check("pop_pc", instr_pc, exp_pc);
                check("pop_data", instr_data, data_of(exp_pc[13:2]));
                check("small_valid", {31'h0, s_instr_valid}, 32'h1);
                check("small_pc", s_instr_pc, {26'h0, exp_pc[5:0]});
                check("small_data", s_instr_data, data_of(exp_pc[13:2]));
                $display("pop %0d pc=%h data=%h small_pc=%h", n_pops, instr_pc, instr_data, s_instr_pc);
                n_pops++;
                exp_pc = (exp_pc + 32'h4) & 32'h3FFF;
            end
            tick();
        end
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        exp_pc         = pc;
        $display("redirect to %h", pc);
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        #1;
        tick();
        tick();
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_fill", {29'h0, fill_count}, 32'h0);
        check("rst_trap", {31'h0, fetch_trap}, 32'h0);
        reset = 1'b0;
        #1;
        check("rst_req_addr", {20'h0, imem_req_addr}, 32'h0);
        check("post_rst_req_valid", {31'h0, imem_req_valid}, 32'h1);

        // Streaming: one instruction per cycle after a two-cycle fill
        exp_pc = 32'h0;
        n_pops = 0;
        run(12);
        check("stream_pops", n_pops, 10);

        // Backpressure: buffer fills to DEPTH, requests stop, nothing left in flight
        instr_ready = 1'b0;
        run(8);
        check("bp_fill", {29'h0, fill_count}, 32'h4);
        check("bp_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("bp_in_flight", addr_q.size(), 0);
        check("bp_small_fill", {29'h0, s_fill_count}, 32'h4);
        instr_ready = 1'b1;
        n_pops = 0;
        run(10);
        check("bp_resume_pops", n_pops, 10);

        // Redirect with two requests outstanding, then a second redirect while flushing
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (addr_q.size() == 2) break;
            run(1);
        end
        check("flush_out2", addr_q.size(), 2);
        redirect_to(32'h80);
        check("flush_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("flush_fill", {29'h0, fill_count}, 32'h0);
        check("flush_req_valid", {31'h0, imem_req_valid}, 32'h0);
        redirect_to(32'h100);
        check("flush_redir_req_valid", {31'h0, imem_req_valid}, 32'h0);
        tick();
        hold = 1'b0;
        tick();
        check("flush_one_left", {31'h0, imem_req_valid}, 32'h0);
        check("flush_one_left_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        check("flush_exit_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("flush_exit_req_addr", {20'h0, imem_req_addr}, 32'h40);
        check("flush_exit_fill", {29'h0, fill_count}, 32'h0);
        n_pops = 0;
        run(8);
        check("flush_pops", n_pops, 6);

        // Misaligned redirect traps; aligned redirect recovers
        redirect_to(32'h102);
        check("trap_set", {31'h0, fetch_trap}, 32'h1);
        check("trap_small_set", {31'h0, s_fetch_trap}, 32'h1);
        check("trap_instr_valid", {31'h0, instr_valid}, 32'h0);
        begin
            int acc0;
            acc0 = n_accepts;
            run(6);
            check("trap_no_accepts", n_accepts, acc0);
        end
        check("trap_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("trap_held", {31'h0, fetch_trap}, 32'h1);
        check("trap_fill", {29'h0, fill_count}, 32'h0);
        redirect_to(32'h200);
        check("trap_cleared", {31'h0, fetch_trap}, 32'h0);
        n_pops = 0;
        run(8);
        check("trap_exit_pops", n_pops, 6);

        // Redirect, response and pop all in one cycle
        check("pre_collide_valid", {31'h0, instr_valid}, 32'h1);
        redirect_to(32'h300);
        check("collide_fill", {29'h0, fill_count}, 32'h0);
        check("collide_instr_valid", {31'h0, instr_valid}, 32'h0);
        n_pops = 0;
        run(8);
        check("collide_pops", n_pops, 5);

        // Word-address wrap on the PC_W=4 instance: 0x3C is followed by 0x00
        redirect_to(32'h3C);
        tick();
        check("wrap_req_addr", {20'h0, imem_req_addr}, 32'hF);
        check("wrap_small_req_addr", {28'h0, s_imem_req_addr}, 32'hF);
        check("wrap_small_req_valid", {31'h0, s_imem_req_valid}, 32'h1);
        n_pops = 0;
        run(7);
        check("wrap_pops", n_pops, 5);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
